// File: rtl/fa_bist_checker.sv
// fa_bist_checker: exhaustive 8-vector self-test of a 1-bit full adder.
// Define FA_BIST_FIRSTFAIL_EN to build the first-mismatch capture (fail_vec/fail_obs).
module fa_bist_checker #(
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_sum,
  input  logic       dut_cout,
  output logic       a,
  output logic       b,
  output logic       cin,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec,
  output logic [1:0] fail_obs
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       mism;
  logic [3:0] err_nxt;
  logic       launch;

  // The stimulus pins are the vector register itself, so they are glitch-free.
  assign {a, b, cin} = vec;
  assign mism    = (dut_sum != (a ^ b ^ cin)) ||
                   (dut_cout != ((a & b) | (a & cin) | (b & cin)));
  assign err_nxt = (mism && err_count != 4'd15) ? err_count + 4'd1 : err_count;
  assign launch  = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (launch) begin
          state     <= APPLY;
          vec       <= '0;
          cnt       <= CNT_INIT;
          err_count <= '0;
          busy      <= 1'b1;
          done      <= 1'b0;
          pass      <= 1'b0;
        end
        APPLY: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 4'd1;
        end
        SAMPLE: begin
          err_count <= err_nxt;
          // pass is taken from err_nxt so a last-vector miss shows on the first DONE cycle
          if (vec == 3'd7 || (STOP_ON_FAIL && mism)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 4'd0);
          end else begin
            state <= APPLY;
            vec   <= vec + 3'd1;
            cnt   <= CNT_INIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FA_BIST_FIRSTFAIL_EN
  logic seen;

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      seen     <= 1'b0;
      fail_vec <= '0;
      fail_obs <= '0;
    end else if (state == SAMPLE && mism && !seen) begin
      seen     <= 1'b1;
      fail_vec <= vec;
      fail_obs <= {dut_sum, dut_cout};
    end
  end
`else
  assign fail_vec = '0;
  assign fail_obs = '0;
`endif

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: three configurations, faulty-adder models driven by
// per-vector corruption masks, expectations queued at start and checked by a monitor.
module tb_fa_bist_checker;
  localparam int NI = 3;

  typedef struct {
    int         id;
    int         s;
    int         n;
    logic [3:0] err;
    logic       pass;
    logic [2:0] fv;
    logic [1:0] fo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] sum, cout, a, b, cin, busy, done, pass;
  logic [3:0] err [NI];
  logic [2:0] fv  [NI];
  logic [1:0] fo  [NI];
  logic [1:0] fmask [NI][8];   // bit1 flips sum, bit0 flips cout

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t last [NI];
  logic [NI-1:0] done_q = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : fa
    wire [1:0] t = 2'(a[g]) + 2'(b[g]) + 2'(cin[g]);
    wire [2:0] v = {a[g], b[g], cin[g]};
    assign sum[g]  = t[0] ^ fmask[g][v][1];
    assign cout[g] = t[1] ^ fmask[g][v][0];
  end

  fa_bist_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .dut_sum(sum[0]), .dut_cout(cout[0]),
    .a(a[0]), .b(b[0]), .cin(cin[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .fail_vec(fv[0]), .fail_obs(fo[0]));
  fa_bist_checker #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .dut_sum(sum[1]), .dut_cout(cout[1]),
    .a(a[1]), .b(b[1]), .cin(cin[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .fail_vec(fv[1]), .fail_obs(fo[1]));
  fa_bist_checker #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .dut_sum(sum[2]), .dut_cout(cout[2]),
    .a(a[2]), .b(b[2]), .cin(cin[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err[2]), .fail_vec(fv[2]), .fail_obs(fo[2]));

  function automatic int settle_of(int id);
    return (id == 2) ? 3 : 1;
  endfunction

  function automatic bit sof_of(int id);
    return id == 1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: walk the 8 vectors, compare observed {sum,cout} against a+b+cin.
  function automatic exp_t model(int id, int s);
    exp_t e;
    int errs, tot;
    bit first;
    logic [1:0] good, obs;
    e.id = id; e.s = s; e.n = 8; e.fv = '0; e.fo = '0;
    errs = 0; first = 0;
    for (int v = 0; v < 8; v++) begin
      tot  = v[2] + v[1] + v[0];
      good = {tot[0], tot[1]};
      obs  = good ^ fmask[id][v];
      if (obs != good) begin
        errs++;
        if (!first) begin first = 1; e.fv = 3'(v); e.fo = obs; end
        if (sof_of(id)) begin e.n = v + 1; break; end
      end
    end
    e.err  = 4'((errs > 15) ? 15 : errs);
    e.pass = (errs == 0);
`ifndef FA_BIST_FIRSTFAIL_EN
    e.fv = '0;
    e.fo = '0;
`endif
    return e;
  endfunction

  // Monitor: checks the walk while busy, results on the first DONE cycle, then stability.
  always @(negedge clk) begin
    int sp, c;
    for (int i = 0; i < NI; i++) begin
      sp = settle_of(i) + 1;
      if (sb.size() > 0 && sb[0].id == i) begin
        c = cyc - sb[0].s;
        if (c >= 1 && c <= sb[0].n * sp) begin
          chk("busy_in_run", busy[i], 1);
          chk("done_in_run", done[i], 0);
          chk("vec_in_run", {a[i], b[i], cin[i]}, (c - 1) / sp);
        end else if (c == sb[0].n * sp + 1) begin
          chk("done_rise", done[i], 1);
          chk("busy_at_done", busy[i], 0);
          chk("err_count", err[i], sb[0].err);
          chk("pass", pass[i], sb[0].pass);
          chk("fail_vec", fv[i], sb[0].fv);
          chk("fail_obs", fo[i], sb[0].fo);
          chk("vec_at_done", {a[i], b[i], cin[i]}, sb[0].n - 1);
          last[i] = sb[0];
          void'(sb.pop_front());
        end
      end else if (done_q[i]) begin
        if (done[i]) begin
          chk("hold_err", err[i], last[i].err);
          chk("hold_pass", pass[i], last[i].pass);
          chk("hold_fail_vec", fv[i], last[i].fv);
          chk("hold_fail_obs", fo[i], last[i].fo);
          chk("hold_vec", {a[i], b[i], cin[i]}, last[i].n - 1);
        end
      end else begin
        chk("idle_done", done[i], 0);
      end
    end
    done_q <= done;
  end

  task automatic chk_zero(int id);
    chk("rst_a", a[id], 0);
    chk("rst_b", b[id], 0);
    chk("rst_cin", cin[id], 0);
    chk("rst_busy", busy[id], 0);
    chk("rst_done", done[id], 0);
    chk("rst_pass", pass[id], 0);
    chk("rst_err", err[id], 0);
    chk("rst_fail_vec", fv[id], 0);
    chk("rst_fail_obs", fo[id], 0);
  endtask

  task automatic wait_empty(int id, bit pulses, int s, int n);
    int c;
    for (int k = 0; k < 400 && sb.size() > 0; k++) begin
      c = cyc - s;
      start[id] = pulses && c <= n * (settle_of(id) + 1) && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    start[id] = 1'b0;
    if (sb.size() > 0) begin
      chk("run_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run(int id, bit pulses);
    exp_t e;
    e = model(id, cyc);
    sb.push_back(e);
    start[id] = 1'b1;
    @(posedge clk); #1;
    start[id] = 1'b0;
    wait_empty(id, pulses, e.s, e.n);
  endtask

  task automatic set_mask(int id, int kind);
    int tot;
    for (int v = 0; v < 8; v++) begin
      tot = v[2] + v[1] + v[0];
      case (kind)
        0: fmask[id][v] = 2'b00;
        1: fmask[id][v] = (tot >= 2) ? 2'b01 : 2'b00;   // cout stuck at 0
        2: fmask[id][v] = 2'b10;                        // sum inverted
        default: fmask[id][v] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      endcase
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e1, e2;
    for (int i = 0; i < NI; i++) set_mask(i, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk_zero(i);
    rst = 1'b0;
    @(posedge clk); #1;

    // good adder, full run, done 17 cycles after start
    run(0, 0);
    chk("good_pass", pass[0], 1);
    chk("good_err", err[0], 0);

    // cout stuck at 0
    set_mask(0, 1);
    run(0, 0);
    chk("stuck_err", err[0], 4);
    chk("stuck_pass", pass[0], 0);
`ifdef FA_BIST_FIRSTFAIL_EN
    chk("stuck_fail_vec", fv[0], 3);
    chk("stuck_fail_obs", fo[0], 0);
`endif

    // same fault, stop at first failure
    set_mask(1, 1);
    run(1, 0);
    chk("sof_err", err[1], 1);
    chk("sof_vec", {a[1], b[1], cin[1]}, 3);

    // SETTLE=3, sum inverted
    set_mask(2, 2);
    run(2, 0);
    chk("inv_err", err[2], 8);
`ifdef FA_BIST_FIRSTFAIL_EN
    chk("inv_fail_vec", fv[2], 0);
    chk("inv_fail_obs", fo[2], 2);
`endif

    // reset during APPLY of vector 4, then a clean rerun
    set_mask(0, 0);
    e1 = model(0, cyc);
    sb.push_back(e1);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int k = 0; k < 20 && cyc != e1.s + 9; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_vec", {a[0], b[0], cin[0]}, 4);
    chk("pre_rst_busy", busy[0], 1);
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero(0);
    rst = 1'b0;
    run(0, 0);

    // start held across a run: no restart while busy, restart straight out of DONE
    set_mask(0, 1);
    e1 = model(0, cyc);
    e2 = model(0, e1.s + 1 + e1.n * 2);
    sb.push_back(e1);
    sb.push_back(e2);
    start[0] = 1'b1;
    for (int k = 0; k < 100 && sb.size() > 1; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("restart_busy", busy[0], 1);
    chk("restart_err_cleared", err[0], 0);
    wait_empty(0, 0, e2.s, e2.n);

    // randomized faults with stray start pulses while busy
    for (int r = 0; r < 30; r++) begin
      int id;
      id = $urandom_range(0, NI - 1);
      set_mask(id, 3);
      run(id, 1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
